// File: rtl/dac_serial_mux_if.sv
// Local-bus and DAC pin bundle for dac_serial_mux.
// The slave side belongs to the mux. The master side drives the command bus
// and the external serial timebase.
interface dac_serial_mux_if #(
    parameter int NCH = 4
);
    logic            xtm_trg;
    logic            xtm_clk;
    logic [31:0]     cmd_dat;
    logic            cmd_str;
    logic            cmd_full;
    logic            busy;
    logic            cmd_ovf;
    logic            cmd_err;
    logic            dac_rst;
    logic            dac_clr;
    logic            dac_clk;
    logic [NCH-1:0]  dac_cs;
    logic            dac_dat;
    logic            dac_lt;

    modport master (
        output xtm_trg, xtm_clk, cmd_dat, cmd_str,
        input  cmd_full, busy, cmd_ovf, cmd_err,
        input  dac_rst, dac_clr, dac_clk, dac_cs, dac_dat, dac_lt
    );

    modport slave (
        input  xtm_trg, xtm_clk, cmd_dat, cmd_str,
        output cmd_full, busy, cmd_ovf, cmd_err,
        output dac_rst, dac_clr, dac_clk, dac_cs, dac_dat, dac_lt
    );
endinterface

// File: rtl/dac_serial_mux.sv
// Multi-channel serial DAC write engine.
// Bus commands are queued in a small FIFO. Each command becomes one of three
// things: a serial frame sent to one chip-select, followed by an optional
// latch pulse; a timed clear pulse; or an error pulse. Every pin change is
// aligned to a falling serial-clock tick, except the chip-select release.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | wait for a queued command and pop it
// ARM     | frame loaded; wait for a tick to pull the chip-select low
// SHIFT   | shift one bit per tick; leave after FRAME_W ticks
// CSHI    | release the chip-select; then latch, or skip the latch if deferred
// LT_LO   | wait for a tick to drive dac_lt low
// LT_HI   | wait for a tick to drive dac_lt high again
// CLR     | first tick drives dac_clr low; it is released CLR_TICKS ticks later
module dac_serial_mux #(
    parameter int FRAME_W    = 24,
    parameter int NCH        = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CLR_TICKS  = 2
) (
    input  logic          bpclk,
    input  logic          lreset,
    dac_serial_mux_if.slave bus
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = 5;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [4:0]  NCH_C   = 5'(NCH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SHIFT,
        S_CSHI,
        S_LT_LO,
        S_LT_HI,
        S_CLR
    } state_t;

    logic [31:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wp_q, rp_q;
    logic [AW:0]        count_q, count_d;
    logic               full_q, ovf_q;
    logic               pop, push, tick;
    logic [31:0]        head;
    logic               unused_head;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         ch_q, ch_d;
    logic               defer_q, defer_d;
    logic [NCH-1:0]     cs_q, cs_d;
    logic               lt_q, lt_d;
    logic               clr_q, clr_d;
    logic               err_q, err_d;

    assign tick = bus.xtm_trg & ~bus.xtm_clk;
    assign head = mem_q[rp_q];
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    // A full FIFO can still take a command when the head leaves in the same cycle.
    assign push = bus.cmd_str && ((count_q != DEPTH_C) || pop);

    // Only some command bits are decoded; the reserved bits are ignored on purpose.
    assign unused_head = ^head;

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // FIFO storage; a flush only resets the pointers, so the contents need no reset.
    always_ff @(posedge bpclk) begin
        if (push) begin
            mem_q[wp_q] <= bus.cmd_dat;
        end
    end

    // FIFO pointers, full flag and the overflow pulse.
    always_ff @(posedge bpclk) begin
        if (!lreset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wp_q <= wp_q + AW'(1);
            end
            if (pop) begin
                rp_q <= rp_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            ovf_q   <= bus.cmd_str && !push;
        end
    end

    // Sequencer next state and pin values.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        defer_d = defer_q;
        cs_d    = cs_q;
        lt_d    = lt_q;
        clr_d   = clr_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (head[31]) begin
                        state_d = S_CLR;
                    end else if ({1'b0, head[27:24]} >= NCH_C) begin
                        err_d = 1'b1;
                    end else begin
                        sr_d    = head[FRAME_W-1:0];
                        cnt_d   = CW'(FRAME_W - 1);
                        ch_d    = head[27:24];
                        defer_d = head[28];
                        state_d = S_ARM;
                    end
                end
            end
            S_ARM: begin
                if (tick) begin
                    for (int i = 0; i < NCH; i++) begin
                        if (ch_q == 4'(i)) begin
                            cs_d[i] = 1'b0;
                        end
                    end
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    sr_d = {sr_q[FRAME_W-2:0], 1'b1};
                    if (cnt_q == '0) begin
                        state_d = S_CSHI;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_CSHI: begin
                cs_d    = '1;
                state_d = defer_q ? S_IDLE : S_LT_LO;
            end
            S_LT_LO: begin
                if (tick) begin
                    lt_d    = 1'b0;
                    state_d = S_LT_HI;
                end
            end
            S_LT_HI: begin
                if (tick) begin
                    lt_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                if (tick) begin
                    if (clr_q) begin
                        clr_d = 1'b0;
                        cnt_d = CW'(CLR_TICKS);
                    end else if (cnt_q == CW'(1)) begin
                        // The counter reaches zero on this tick, so dac_clr is released now.
                        cnt_d   = '0;
                        clr_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers; a reset puts every pin in its inactive level on the same edge.
    always_ff @(posedge bpclk) begin
        if (!lreset) begin
            state_q <= S_IDLE;
            sr_q    <= '1;
            cnt_q   <= '0;
            ch_q    <= '0;
            defer_q <= 1'b0;
            cs_q    <= '1;
            lt_q    <= 1'b1;
            clr_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            defer_q <= defer_d;
            cs_q    <= cs_d;
            lt_q    <= lt_d;
            clr_q   <= clr_d;
            err_q   <= err_d;
        end
    end

    assign bus.cmd_full = full_q;
    assign bus.busy     = (state_q != S_IDLE) || (count_q != '0);
    assign bus.cmd_ovf  = ovf_q;
    assign bus.cmd_err  = err_q;
    assign bus.dac_rst  = lreset;
    assign bus.dac_clr  = clr_q;
    assign bus.dac_clk  = bus.xtm_clk;
    assign bus.dac_cs   = cs_q;
    assign bus.dac_dat  = sr_q[FRAME_W-1];
    assign bus.dac_lt   = lt_q;

endmodule

// File: tb/tb_dac_serial_mux.sv
// Directed bench for dac_serial_mux. A pin monitor turns the DAC pins into a
// stream of events: frames, latch pulses, clear pulses and error pulses. These
// are checked in order against events the bench predicts from each accepted
// command.
module tb_dac_serial_mux;

    localparam int FRAME_W    = 24;
    localparam int NCH        = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CLR_TICKS  = 2;

    localparam int K_FRAME = 0;
    localparam int K_LATCH = 1;
    localparam int K_CLR   = 2;
    localparam int K_ERR   = 3;

    typedef struct {
        int          kind;
        int          ch;
        logic [31:0] data;
        int          len;
        int          ticks;
    } ev_t;

    logic bpclk  = 1'b0;
    logic lreset = 1'b0;

    dac_serial_mux_if #(.NCH(NCH)) bus ();

    dac_serial_mux #(
        .FRAME_W    (FRAME_W),
        .NCH        (NCH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CLR_TICKS  (CLR_TICKS)
    ) dut (
        .bpclk  (bpclk),
        .lreset (lreset),
        .bus    (bus)
    );

    always #5 bpclk = ~bpclk;

    int  n_cmp  = 0;
    int  n_fail = 0;
    ev_t exp_q[$];

    int          n_frames = 0;
    int          n_latch  = 0;
    int          n_clr    = 0;
    int          n_err    = 0;
    int          n_ovf    = 0;
    logic [31:0] last_data = '0;
    int          last_ch   = -1;
    int          last_clr_len = -1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    // Expected pin-level events for one accepted command.
    function automatic void model_cmd(logic [31:0] c);
        ev_t e;
        if (c[31]) begin
            e = '{kind: K_CLR, ch: 0, data: 32'd0, len: CLR_TICKS, ticks: 0};
            exp_q.push_back(e);
        end else if (int'(c[27:24]) >= NCH) begin
            e = '{kind: K_ERR, ch: 0, data: 32'd0, len: 0, ticks: 0};
            exp_q.push_back(e);
        end else begin
            e = '{kind: K_FRAME, ch: int'(c[27:24]),
                  data: c % (32'd1 << FRAME_W), len: FRAME_W, ticks: FRAME_W};
            exp_q.push_back(e);
            if (!c[28]) begin
                e = '{kind: K_LATCH, ch: 0, data: 32'd0, len: 1, ticks: 0};
                exp_q.push_back(e);
            end
        end
    endfunction

    function automatic void got_event(ev_t a);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got kind=%0d ch=%0d data=%h len=%0d ticks=%0d, required no event",
                     a.kind, a.ch, a.data, a.len, a.ticks);
        end else begin
            e = exp_q.pop_front();
            if (a.kind != e.kind || a.ch != e.ch || a.data !== e.data ||
                a.len != e.len || a.ticks != e.ticks) begin
                n_fail++;
                $display("FAIL event: got kind=%0d ch=%0d data=%h len=%0d ticks=%0d, required kind=%0d ch=%0d data=%h len=%0d ticks=%0d",
                         a.kind, a.ch, a.data, a.len, a.ticks,
                         e.kind, e.ch, e.data, e.len, e.ticks);
            end
        end
    endfunction

    // Serial timebase: xtm_clk toggles every 4 bpclk cycles, with a one-cycle trigger.
    initial begin
        int div;
        div         = 0;
        bus.xtm_clk = 1'b0;
        bus.xtm_trg = 1'b0;
        forever begin
            @(negedge bpclk);
            div++;
            if (div == 4) begin
                div         = 0;
                bus.xtm_clk = ~bus.xtm_clk;
                bus.xtm_trg = 1'b1;
            end else begin
                bus.xtm_trg = 1'b0;
            end
        end
    end

    // Pin monitor and per-cycle checks, sampled 1 time unit after each rising edge.
    logic [NCH-1:0] prev_cs;
    logic           prev_xclk;
    bit             in_fr, lt_act, clr_act;
    ev_t            fr;
    int             lt_cnt, clr_cnt;

    initial begin
        prev_cs   = '1;
        prev_xclk = 1'b0;
        in_fr     = 1'b0;
        lt_act    = 1'b0;
        clr_act   = 1'b0;
        lt_cnt    = 0;
        clr_cnt   = 0;
        fr        = '{kind: K_FRAME, ch: 0, data: 32'd0, len: 0, ticks: 0};
    end

    always begin
        logic tk;
        @(posedge bpclk);
        #1;
        chk("dac_rst_follows_lreset", 32'(bus.dac_rst), 32'(lreset));
        chk("dac_clk_follows_xtm_clk", 32'(bus.dac_clk), 32'(bus.xtm_clk));
        if (!lreset) begin
            in_fr   = 1'b0;
            lt_act  = 1'b0;
            clr_act = 1'b0;
        end else begin
            tk = bus.xtm_trg & ~bus.xtm_clk;
            chk("cs_at_most_one_low", 32'($countones(~bus.dac_cs) <= 1), 32'd1);
            if (!bus.dac_clr) begin
                chk("clear_leaves_cs_lt_high", {30'd0, bus.dac_cs == '1, bus.dac_lt}, 32'd3);
            end
            if (!in_fr) begin
                if (bus.dac_cs != '1) begin
                    in_fr = 1'b1;
                    fr    = '{kind: K_FRAME, ch: 0, data: 32'd0, len: 0, ticks: 0};
                    for (int i = 0; i < NCH; i++) begin
                        if (!bus.dac_cs[i]) fr.ch = i;
                    end
                end
            end else begin
                if (tk) fr.ticks++;
                if (bus.xtm_clk && !prev_xclk && bus.dac_cs != '1) begin
                    fr.data = {fr.data[30:0], bus.dac_dat};
                    fr.len++;
                end
                if (bus.dac_cs == '1) begin
                    in_fr = 1'b0;
                    n_frames++;
                    last_data = fr.data;
                    last_ch   = fr.ch;
                    got_event(fr);
                end
            end
            if (lt_act) begin
                if (tk) lt_cnt++;
                if (bus.dac_lt) begin
                    lt_act = 1'b0;
                    n_latch++;
                    got_event('{kind: K_LATCH, ch: 0, data: 32'd0, len: lt_cnt, ticks: 0});
                end
            end else if (!bus.dac_lt) begin
                lt_act = 1'b1;
                lt_cnt = 0;
            end
            if (clr_act) begin
                if (tk) clr_cnt++;
                if (bus.dac_clr) begin
                    clr_act = 1'b0;
                    n_clr++;
                    last_clr_len = clr_cnt;
                    got_event('{kind: K_CLR, ch: 0, data: 32'd0, len: clr_cnt, ticks: 0});
                end
            end else if (!bus.dac_clr) begin
                clr_act = 1'b1;
                clr_cnt = 0;
            end
            if (bus.cmd_err) begin
                n_err++;
                got_event('{kind: K_ERR, ch: 0, data: 32'd0, len: 0, ticks: 0});
            end
            if (bus.cmd_ovf) n_ovf++;
        end
        prev_cs   = bus.dac_cs;
        prev_xclk = bus.xtm_clk;
    end

    // Present one strobe cycle; the strobe is left high so calls can run back to back.
    task automatic send(input logic [31:0] c, input bit acc);
        @(negedge bpclk);
        bus.cmd_dat = c;
        bus.cmd_str = 1'b1;
        @(posedge bpclk);
        #1;
        chk("cmd_ovf_after_strobe", 32'(bus.cmd_ovf), 32'(!acc));
        if (acc) model_cmd(c);
    endtask

    task automatic release_str();
        @(negedge bpclk);
        bus.cmd_str = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge bpclk);
            #1;
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_idle_in_budget", 32'(ok), 32'd1);
        repeat (4) @(posedge bpclk);
        #2;
    endtask

    task automatic wait_cs_low(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge bpclk);
            #1;
            if (bus.dac_cs != '1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_cs_low_in_budget", 32'(ok), 32'd1);
    endtask

    task automatic check_drained(input string name);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] burst_cmd [6] = '{32'h0000_0101, 32'h1100_0202, 32'h0200_0303,
                                   32'h0300_0404, 32'h0000_0505, 32'h0100_0606};
    bit          burst_acc [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int frames_before, ovf_before;
        bit busy_seen;
        bus.cmd_dat = '0;
        bus.cmd_str = 1'b0;
        lreset      = 1'b0;

        // Reset state.
        repeat (3) @(posedge bpclk);
        #1;
        chk("reset_cs", 32'(bus.dac_cs), 32'hF);
        chk("reset_lt", 32'(bus.dac_lt), 32'd1);
        chk("reset_clr", 32'(bus.dac_clr), 32'd1);
        chk("reset_dat", 32'(bus.dac_dat), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_full", 32'(bus.cmd_full), 32'd0);
        chk("reset_ovf_err", {30'd0, bus.cmd_ovf, bus.cmd_err}, 32'd0);
        @(negedge bpclk);
        lreset = 1'b1;

        // Single frame to channel 0, with a latch.
        send(32'h00AB_CDEF, 1'b1);
        chk("busy_after_cmd", 32'(bus.busy), 32'd1);
        release_str();
        wait_idle(1000);
        check_drained("t1_drained");
        chk("t1_frame_data", last_data, 32'h00AB_CDEF);
        chk("t1_frame_ch", 32'(last_ch), 32'd0);
        chk("t1_latch_count", 32'(n_latch), 32'd1);
        chk("t1_busy_low", 32'(bus.busy), 32'd0);

        // A deferred frame, then a normal one: the two share a single latch.
        send(32'h1100_1234, 1'b1);
        send(32'h0200_5678, 1'b1);
        release_str();
        wait_idle(2000);
        check_drained("t2_drained");
        chk("t2_latch_count", 32'(n_latch), 32'd2);
        chk("t2_frame_count", 32'(n_frames), 32'd3);
        chk("t2_last_frame", last_data, 32'h0000_5678);

        // Overflow: six strobes while a frame is shifting; the last two are dropped.
        ovf_before = n_ovf;
        send(32'h0300_00A5, 1'b1);
        release_str();
        wait_cs_low(200);
        for (int i = 0; i < 6; i++) begin
            send(burst_cmd[i], burst_acc[i]);
            if (i == 2) chk("t3_not_full_at_3", 32'(bus.cmd_full), 32'd0);
            if (i == 3) chk("t3_full_at_4", 32'(bus.cmd_full), 32'd1);
        end
        release_str();
        chk("t3_full_after_burst", 32'(bus.cmd_full), 32'd1);
        wait_idle(5000);
        check_drained("t3_drained");
        chk("t3_ovf_pulses", 32'(n_ovf - ovf_before), 32'd2);
        chk("t3_last_frame", last_data, 32'h0000_0404);

        // A channel beyond NCH is an error, and the next command runs normally.
        send(32'h0500_00AA, 1'b1);
        send(32'h0000_0055, 1'b1);
        release_str();
        wait_idle(1000);
        check_drained("t4_drained");
        chk("t4_err_count", 32'(n_err), 32'd1);
        chk("t4_last_frame", last_data, 32'h0000_0055);
        chk("t4_last_ch", 32'(last_ch), 32'd0);

        // Clear pulse.
        send(32'h8000_0000, 1'b1);
        release_str();
        wait_idle(500);
        check_drained("t5_drained");
        chk("t5_clr_count", 32'(n_clr), 32'd1);
        chk("t5_clr_len", 32'(last_clr_len), 32'd2);

        // Reset mid-frame discards the frame and the queued commands.
        frames_before = n_frames;
        send(32'h0000_0F0F, 1'b1);
        send(32'h0100_1111, 1'b1);
        send(32'h0200_2222, 1'b1);
        release_str();
        wait_cs_low(200);
        repeat (40) @(posedge bpclk);
        @(negedge bpclk);
        lreset = 1'b0;
        exp_q.delete();
        @(posedge bpclk);
        #1;
        chk("t6_cs_high", 32'(bus.dac_cs), 32'hF);
        chk("t6_lt_high", 32'(bus.dac_lt), 32'd1);
        chk("t6_dat_high", 32'(bus.dac_dat), 32'd1);
        chk("t6_busy_low", 32'(bus.busy), 32'd0);
        chk("t6_full_low", 32'(bus.cmd_full), 32'd0);
        @(negedge bpclk);
        lreset = 1'b1;
        busy_seen = 1'b0;
        repeat (300) begin
            @(posedge bpclk);
            #1;
            if (bus.busy) busy_seen = 1'b1;
        end
        chk("t6_quiet_after_reset", 32'(busy_seen), 32'd0);
        chk("t6_no_new_frames", 32'(n_frames), 32'(frames_before));
        check_drained("t6_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: got time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "time limit");
    end

endmodule
